noc_indication_serializer: RTL and testbench
============================================

Name: noc_indication_serializer

Overview:
- Transmit-side counterpart of the request-pipe decoder. It takes `heard` method invocations from the DUT and frames each one as a portal NOC message on a narrow 32-bit beat pipe toward the host.
- Each message is a header beat followed by a payload beat. The header carries the method selector in its upper 16 bits, so the far-end decoder's `== 16'd0` selector match applies unchanged.
- The block sits between the DUT indication interface and the outbound NOC pipe. It replaces the direct method-to-pipe wrapper when the link is beat-serial.

Parameters:
- METHOD_ID, 0, 16-bit selector placed in header bits [31:16].
- DEPTH, 2, pending-message FIFO entries; power of two, ≥ 2.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- heard__ENA  input  1  method invocation strobe; legal only while heard__RDY = 1.
- heard$v  input  32  method argument.
- heard__RDY  output  1  method guard; FIFO can accept a message.
- pipe$enq__ENA  output  1  beat transfer strobe; asserted only when pipe$enq__RDY = 1.
- pipe$enq$v  output  32  beat data.
- pipe$enq__RDY  input  1  downstream guard.
- msg_count  output  $clog2(DEPTH+1)  messages queued, not yet fully sent.

Behaviour:
- Reset (RST high at a clock edge):
  - FIFO flushed, count 0, FSM → HDR.
  - While RST is high, heard__RDY = 0 and pipe$enq__ENA = 0; both outputs are forced low combinationally by RST.
  - Reset asserted mid-message drops the partial message; no payload beat follows the orphaned header.
- heard__RDY = !RST && (count < DEPTH), decoded from registered count.
  - No bypass: when full, RDY stays 0 even in a cycle where a pop occurs.
- Push: on heard__ENA && heard__RDY, heard$v is written at the tail; count increments next edge.
  - ENA while RDY = 0 is a protocol violation; it is ignored with no state change.
- FSM, 2 states (3 with the optional feature):
  - HDR:
    - valid = (count != 0).
    - pipe$enq$v = {METHOD_ID[15:0], LEN}, where LEN = 16'd1.
    - pipe$enq__ENA = valid && pipe$enq__RDY.
    - On ENA → DATA.
  - DATA:
    - valid = 1; pipe$enq$v = FIFO head.
    - On ENA: pop the head → HDR (or → SEQ when the optional feature is enabled).
- Ordering: messages leave in push order. Beats of one message are never interleaved with another message.
- Latency with RDY held high:
  - push at edge t → header beat at cycle t+1 → payload beat at cycle t+2.
  - Back-to-back messages stream at 2 beats per message with no bubble.
- Backpressure: while pipe$enq__RDY = 0, the state and pipe$enq$v are held stable; the beat repeats until accepted.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- msg_count = count. It decrements on the payload pop, or on the SEQ beat when the optional feature is enabled.

Optional Feature:
- Macro NOC_SEQ_EN.
- When defined:
  - LEN = 16'd2.
  - Third state SEQ follows DATA. It emits {16'h0000, seq[15:0]} and then returns to HDR.
  - seq is 16 bits, reset to 0, increments on each SEQ beat accepted, and wraps 16'hFFFF → 16'h0000.
  - The FIFO pop moves to the SEQ beat, so the message slot is held until the whole message is sent.
- When undefined: no seq register, no SEQ state, LEN = 16'd1, and the 2-beat framing described in Behaviour.

Test Plan:
- After reset with pipe RDY = 1: one push of heard$v = 32'hDEADBEEF. Required: beat 32'h0000_0001 at t+1, then 32'hDEADBEEF at t+2; msg_count returns to 0; heard__RDY stays high throughout.
- Fill test: DEPTH = 2, pipe RDY = 0, push 32'h11 and 32'h22. Required: heard__RDY = 0 and msg_count = 2. Then set RDY = 1. Required beats: 0x0000_0001, 0x11, 0x0000_0001, 0x22. heard__RDY returns high on the cycle after the first payload pop.
- Backpressure: toggle pipe$enq__RDY 1,0,0,1 during a message. Required: pipe$enq$v held stable across the stall cycles; no duplicated beat and no dropped beat.
- Simultaneous: queue 32'hA, then push 32'hB in the same cycle the payload 32'hA pops. Required: msg_count stays 1 and 32'hB's header follows immediately.
- Mid-message reset: assert RST for 1 cycle right after a header is accepted. Required: no payload beat; outputs 0 during reset; heard__RDY = 1 and msg_count = 0 after.
- With NOC_SEQ_EN: send 3 messages. Required: headers 0x0000_0002 and seq beats 0x0, 0x1, 0x2. Force seq to 16'hFFFF. Required: next seq beat 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/noc_indication_serializer.sv
// Frames each `heard` method call as a header beat plus a payload beat on a 32-bit NOC pipe.
// Defining NOC_SEQ_EN adds a trailing sequence-number beat per message (LEN becomes 2).
module noc_indication_serializer #(
   parameter logic [15:0] METHOD_ID = 16'd0,
   parameter int          DEPTH     = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       heard__ENA,
   input  logic [31:0]                heard_v,
   output logic                       heard__RDY,
   output logic                       pipe_enq__ENA,
   output logic [31:0]                pipe_enq_v,
   input  logic                       pipe_enq__RDY,
   output logic [$clog2(DEPTH+1)-1:0] msg_count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
`ifdef NOC_SEQ_EN
   localparam logic [1:0] ST_SEQ  = 2'd2;
   localparam logic [15:0] LEN    = 16'd2;
`else
   localparam logic [15:0] LEN    = 16'd1;
`endif

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          valid;
   logic          push;
   logic          pop;
`ifdef NOC_SEQ_EN
   logic [15:0]   seq;
`endif

   // Guard comes from registered count only, so a full FIFO never accepts in a pop cycle.
   assign heard__RDY    = !RST && (count < CW'(DEPTH));
   assign push          = heard__ENA && heard__RDY;
   assign pipe_enq__ENA = !RST && valid && pipe_enq__RDY;
   assign msg_count     = count;

   always_comb begin
      valid      = 1'b1;
      pipe_enq_v = mem[head];
      case (state)
         ST_HDR: begin
            valid      = (count != '0);
            pipe_enq_v = {METHOD_ID, LEN};
         end
         ST_DATA: ;
`ifdef NOC_SEQ_EN
         ST_SEQ:  pipe_enq_v = {16'h0000, seq};
`endif
         default: valid = 1'b0;
      endcase
   end

   // The slot is released only on the last beat of a message.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         ST_HDR:  if (pipe_enq__ENA) state_next = ST_DATA;
`ifdef NOC_SEQ_EN
         ST_DATA: if (pipe_enq__ENA) state_next = ST_SEQ;
         ST_SEQ: begin
            if (pipe_enq__ENA) begin
               state_next = ST_HDR;
               pop        = 1'b1;
            end
         end
`else
         ST_DATA: begin
            if (pipe_enq__ENA) begin
               state_next = ST_HDR;
               pop        = 1'b1;
            end
         end
`endif
         default: state_next = ST_HDR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= ST_HDR;
`ifdef NOC_SEQ_EN
         seq   <= 16'h0000;
`endif
      end else begin
         state <= state_next;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
`ifdef NOC_SEQ_EN
         if (pop) seq <= seq + 16'd1;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[tail] <= heard_v;
   end

endmodule

// File: tb/tb_noc_indication_serializer.sv
// Directed self-checking bench for noc_indication_serializer (DEPTH = 2, METHOD_ID = 0).
// Build with NOC_SEQ_EN defined to exercise the sequence-beat variant.
`timescale 1ns/1ps
module tb_noc_indication_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        heard_ena = 1'b0;
   logic [31:0] heard_v = 32'h0;
   logic        heard_rdy;
   logic        enq_ena;
   logic [31:0] enq_v;
   logic        enq_rdy = 1'b0;
   logic [1:0]  msg_count;

   int passed = 0;
   int total  = 0;

   noc_indication_serializer #(.METHOD_ID(16'd0), .DEPTH(2)) dut (
      .CLK           (clk),
      .RST           (rst),
      .heard__ENA    (heard_ena),
      .heard_v       (heard_v),
      .heard__RDY    (heard_rdy),
      .pipe_enq__ENA (enq_ena),
      .pipe_enq_v    (enq_v),
      .pipe_enq__RDY (enq_rdy),
      .msg_count     (msg_count)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are looked at 1 ns later.
   task automatic drive(input logic ena, input logic [31:0] v, input logic prdy);
      @(negedge clk);
      heard_ena = ena;
      heard_v   = v;
      enq_rdy   = prdy;
      #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      drive(1'b1, 32'h99, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, msg_count} !== 4'b0000)
         $display("[TB] FAIL reset_hold: rdy/ena/count=%b want 0000", {heard_rdy, enq_ena, msg_count});
      else passed++;
      @(negedge clk);
      rst       = 1'b0;
      heard_ena = 1'b0;
      #1;
      total++;
      if ({heard_rdy, enq_ena, msg_count} !== 4'b1000)
         $display("[TB] FAIL reset_exit: rdy/ena/count=%b want 1000", {heard_rdy, enq_ena, msg_count});
      else passed++;
   endtask

   task automatic test_single;
      drive(1'b1, 32'hDEADBEEF, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, enq_v, msg_count} !== {1'b1, 1'b1, 32'h0000_0001, 2'd1})
         $display("[TB] FAIL single_hdr: rdy=%b ena=%b v=%h cnt=%0d want 1 1 00000001 1", heard_rdy, enq_ena, enq_v, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, enq_v} !== {1'b1, 1'b1, 32'hDEADBEEF})
         $display("[TB] FAIL single_data: rdy=%b ena=%b v=%h want 1 1 deadbeef", heard_rdy, enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, msg_count} !== {1'b1, 1'b0, 2'd0})
         $display("[TB] FAIL single_done: rdy=%b ena=%b cnt=%0d want 1 0 0", heard_rdy, enq_ena, msg_count);
      else passed++;
   endtask

   task automatic test_fill;
      drive(1'b1, 32'h11, 1'b0);
      drive(1'b1, 32'h22, 1'b0);
      total++;
      if (heard_rdy !== 1'b1)
         $display("[TB] FAIL fill_half_rdy: rdy=%b want 1", heard_rdy);
      else passed++;
      // Illegal strobe while full must be ignored.
      drive(1'b1, 32'h33, 1'b0);
      total++;
      if ({heard_rdy, enq_ena, msg_count} !== {1'b0, 1'b0, 2'd2})
         $display("[TB] FAIL fill_full: rdy=%b ena=%b cnt=%0d want 0 0 2", heard_rdy, enq_ena, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v, msg_count} !== {1'b1, 32'h0000_0001, 2'd2})
         $display("[TB] FAIL fill_hdr1: ena=%b v=%h cnt=%0d want 1 00000001 2", enq_ena, enq_v, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, enq_v} !== {1'b0, 1'b1, 32'h11})
         $display("[TB] FAIL fill_data1: rdy=%b ena=%b v=%h want 0 1 00000011", heard_rdy, enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, enq_v, msg_count} !== {1'b1, 1'b1, 32'h0000_0001, 2'd1})
         $display("[TB] FAIL fill_hdr2: rdy=%b ena=%b v=%h cnt=%0d want 1 1 00000001 1", heard_rdy, enq_ena, enq_v, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v} !== {1'b1, 32'h22})
         $display("[TB] FAIL fill_data2: ena=%b v=%h want 1 00000022", enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, msg_count} !== {1'b0, 2'd0})
         $display("[TB] FAIL fill_done: ena=%b cnt=%0d want 0 0", enq_ena, msg_count);
      else passed++;
   endtask

   task automatic test_backpressure;
      drive(1'b1, 32'h55, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v} !== {1'b1, 32'h0000_0001})
         $display("[TB] FAIL bp_hdr: ena=%b v=%h want 1 00000001", enq_ena, enq_v);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b0);
         total++;
         if ({enq_ena, enq_v, msg_count} !== {1'b0, 32'h55, 2'd1})
            $display("[TB] FAIL bp_stall%0d: ena=%b v=%h cnt=%0d want 0 00000055 1", i, enq_ena, enq_v, msg_count);
         else passed++;
      end
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v} !== {1'b1, 32'h55})
         $display("[TB] FAIL bp_data: ena=%b v=%h want 1 00000055", enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, msg_count} !== {1'b0, 2'd0})
         $display("[TB] FAIL bp_done: ena=%b cnt=%0d want 0 0", enq_ena, msg_count);
      else passed++;
   endtask

   task automatic test_simultaneous;
      drive(1'b1, 32'hA, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b1, 32'hB, 1'b1);
      total++;
      if ({heard_rdy, enq_ena, enq_v} !== {1'b1, 1'b1, 32'hA})
         $display("[TB] FAIL sim_data_a: rdy=%b ena=%b v=%h want 1 1 0000000a", heard_rdy, enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v, msg_count} !== {1'b1, 32'h0000_0001, 2'd1})
         $display("[TB] FAIL sim_hdr_b: ena=%b v=%h cnt=%0d want 1 00000001 1", enq_ena, enq_v, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v} !== {1'b1, 32'hB})
         $display("[TB] FAIL sim_data_b: ena=%b v=%h want 1 0000000b", enq_ena, enq_v);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, msg_count} !== {1'b0, 2'd0})
         $display("[TB] FAIL sim_done: ena=%b cnt=%0d want 0 0", enq_ena, msg_count);
      else passed++;
   endtask

   task automatic test_mid_reset;
      drive(1'b1, 32'h77, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, enq_v} !== {1'b1, 32'h0000_0001})
         $display("[TB] FAIL mr_hdr: ena=%b v=%h want 1 00000001", enq_ena, enq_v);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({heard_rdy, enq_ena} !== 2'b00)
         $display("[TB] FAIL mr_during: rdy=%b ena=%b want 0 0", heard_rdy, enq_ena);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({heard_rdy, enq_ena, msg_count} !== {1'b1, 1'b0, 2'd0})
         $display("[TB] FAIL mr_after: rdy=%b ena=%b cnt=%0d want 1 0 0", heard_rdy, enq_ena, msg_count);
      else passed++;
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if (enq_ena !== 1'b0)
         $display("[TB] FAIL mr_no_payload: ena=%b v=%h want ena 0", enq_ena, enq_v);
      else passed++;
   endtask

`ifdef NOC_SEQ_EN
   task automatic test_seq;
      logic [15:0] exp_seq [5];
      exp_seq[0] = 16'h0000;
      exp_seq[1] = 16'h0001;
      exp_seq[2] = 16'h0002;
      exp_seq[3] = 16'hFFFF;
      exp_seq[4] = 16'h0000;
      for (int m = 0; m < 5; m++) begin
         if (m == 3) begin
            @(negedge clk);
            dut.seq = 16'hFFFF;
         end
         drive(1'b1, 32'h100 + m, 1'b1);
         drive(1'b0, 32'h0, 1'b1);
         total++;
         if ({enq_ena, enq_v} !== {1'b1, 32'h0000_0002})
            $display("[TB] FAIL seq_hdr%0d: ena=%b v=%h want 1 00000002", m, enq_ena, enq_v);
         else passed++;
         drive(1'b0, 32'h0, 1'b1);
         total++;
         if ({enq_ena, enq_v} !== {1'b1, 32'h100 + m})
            $display("[TB] FAIL seq_data%0d: ena=%b v=%h want 1 %h", m, enq_ena, enq_v, 32'h100 + m);
         else passed++;
         drive(1'b0, 32'h0, 1'b1);
         total++;
         if ({enq_ena, enq_v, msg_count} !== {1'b1, 16'h0000, exp_seq[m], 2'd1})
            $display("[TB] FAIL seq_beat%0d: ena=%b v=%h cnt=%0d want 1 %h 1", m, enq_ena, enq_v, msg_count, {16'h0000, exp_seq[m]});
         else passed++;
      end
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({enq_ena, msg_count} !== {1'b0, 2'd0})
         $display("[TB] FAIL seq_done: ena=%b cnt=%0d want 0 0", enq_ena, msg_count);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef NOC_SEQ_EN
      test_seq();
`else
      test_single();
      test_fill();
      test_backpressure();
      test_simultaneous();
      test_mid_reset();
`endif
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
